// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, init table and state encodings.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam int unsigned INIT_LEN = 5;

  typedef enum logic [1:0] {SeqInit, SeqIdle, SeqDigits} seq_state_e;
  typedef enum logic [2:0] {TxIdle, TxSetup, TxBitLo, TxBitHi, TxLatch} tx_state_e;

  // Init frame idx of the power-up sequence; idx 4 and beyond map to intensity.
  function automatic logic [15:0] init_frame(input logic [3:0] idx, input logic [3:0] intensity);
    logic [15:0] f;
    case (idx)
      4'd0:    f = {4'h0, ADDR_TEST, 8'h00};
      4'd1:    f = {4'h0, ADDR_SHUTDOWN, 8'h01};
      4'd2:    f = {4'h0, ADDR_DECODE, 8'h00};
      4'd3:    f = {4'h0, ADDR_SCANLIMIT, 8'h07};
      default: f = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/max7219_frame_tx.sv
// Serialises one 16-bit frame: load low, setup, 16 clocked bits, latch.
module max7219_frame_tx
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [15:0] data,
  output logic        ready,
  output logic        sclk,
  output logic        dout,
  output logic        load
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  tx_state_e   state;
  logic [7:0]  cnt;
  logic [3:0]  bits_left;
  logic [14:0] shreg;     // bits still to be sent after the one on dout
  logic        accept;

  // Ready also in the last latch cycle so back-to-back frames are exactly 34*CLK_DIV.
  always_comb begin
    ready  = (state == TxIdle) || (state == TxLatch && cnt == 8'd0);
    accept = valid && ready;
  end

  // Frame FSM with registered serial outputs; dout only moves while sclk is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= TxIdle;
      cnt       <= 8'd0;
      bits_left <= 4'd0;
      shreg     <= '0;
      sclk      <= 1'b0;
      dout      <= 1'b0;
      load      <= 1'b1;
    end else if (accept) begin
      state     <= TxSetup;
      cnt       <= DIV_LAST;
      bits_left <= 4'd15;
      shreg     <= data[14:0];
      dout      <= data[15];
      load      <= 1'b0;
    end else begin
      case (state)
        TxSetup: begin
          if (cnt == 8'd0) begin
            state <= TxBitLo;
            cnt   <= DIV_LAST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TxBitLo: begin
          if (cnt == 8'd0) begin
            state <= TxBitHi;
            cnt   <= DIV_LAST;
            sclk  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TxBitHi: begin
          if (cnt == 8'd0) begin
            sclk <= 1'b0;
            cnt  <= DIV_LAST;
            if (bits_left == 4'd0) begin
              state <= TxLatch;
              load  <= 1'b1;
            end else begin
              state     <= TxBitLo;
              bits_left <= bits_left - 4'd1;
              dout      <= shreg[14];
              shreg     <= {shreg[13:0], 1'b0};
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TxLatch: begin
          if (cnt == 8'd0) begin
            state <= TxIdle;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= TxIdle;
      endcase
    end
  end

endmodule

// File: rtl/max7219_serial_tx.sv
// MAX7219 driver: init sequence after reset, then 8-digit refreshes on request.
module max7219_serial_tx
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_update,
  input  logic [63:0] i_digits,
  output logic        o_serial_clk,
  output logic        o_serial_dout,
  output logic        o_serial_load,
  output logic        o_busy
);

  seq_state_e  state;
  logic [3:0]  idx;        // next frame of the current sequence
  logic        pending;
  logic [63:0] snapshot;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic        seq_done;

  // Frame source for the current sequence position; done once the last frame has latched.
  always_comb begin
    frame_valid = 1'b0;
    frame_data  = '0;
    case (state)
      SeqInit: begin
        frame_valid = idx < 4'(INIT_LEN);
        frame_data  = init_frame(idx, INTENSITY);
      end
      SeqDigits: begin
        frame_valid = !idx[3];
        frame_data  = {4'h0, ADDR_DIGIT0 + idx, snapshot[{idx[2:0], 3'b000} +: 8]};
      end
      default: ;
    endcase
    seq_done = frame_ready &&
               ((state == SeqInit && idx == 4'(INIT_LEN)) || (state == SeqDigits && idx[3]));
  end

  // Sequencer, snapshot and one-deep pending request; busy is registered alongside.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= SeqInit;
      idx      <= 4'd0;
      pending  <= 1'b0;
      snapshot <= '0;
      o_busy   <= 1'b1;
    end else begin
      case (state)
        SeqIdle: begin
          if (i_update) begin
            snapshot <= i_digits;
            idx      <= 4'd0;
            state    <= SeqDigits;
            o_busy   <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        SeqInit, SeqDigits: begin
          if (seq_done) begin
            idx <= 4'd0;
            // A strobe in this very cycle counts as pending.
            if (pending || i_update) begin
              snapshot <= i_digits;
              pending  <= 1'b0;
              state    <= SeqDigits;
              o_busy   <= 1'b1;
            end else begin
              state  <= SeqIdle;
              o_busy <= 1'b0;
            end
          end else begin
            if (frame_valid && frame_ready) idx <= idx + 4'd1;
            if (i_update) pending <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        default: state <= SeqInit;
      endcase
    end
  end

  max7219_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_frame_tx (
    .clk   (i_clk),
    .reset (i_reset),
    .valid (frame_valid),
    .data  (frame_data),
    .ready (frame_ready),
    .sclk  (o_serial_clk),
    .dout  (o_serial_dout),
    .load  (o_serial_load)
  );

endmodule

// File: tb/tb_max7219_serial_tx.sv
// Directed bench: decodes frames from the serial pins and checks them against hand values.
module tb_max7219_serial_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [63:0] digits = '0;
  logic        sclk0, dout0, load0, busy0;
  logic        sclk1, dout1, load1, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  max7219_serial_tx dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_update      (update),
    .i_digits      (digits),
    .o_serial_clk  (sclk0),
    .o_serial_dout (dout0),
    .o_serial_load (load0),
    .o_busy        (busy0)
  );

  max7219_serial_tx #(
    .CLK_DIV   (1),
    .INTENSITY (4'hF)
  ) dut1 (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_update      (update),
    .i_digits      (digits),
    .o_serial_clk  (sclk1),
    .o_serial_dout (dout1),
    .o_serial_load (load1),
    .o_busy        (busy1)
  );

  // Monitor / mock receiver for the default instance
  logic [15:0] frames0[$];
  int          lowlen0[$];
  int          falls0[$];
  logic [7:0]  digit_reg[8];
  int cyc0 = 0, fall0 = 0, nb0 = 0, viol0 = 0, aborts0 = 0;
  logic pl0 = 1'b1, ps0 = 1'b0, pd0 = 1'b0;
  logic [15:0] sh0 = '0;

  always @(negedge clk) begin
    cyc0++;
    if (dout0 !== pd0 && sclk0 === 1'b1) viol0++;
    if (sclk0 === 1'b1 && load0 === 1'b1) viol0++;
    if (pl0 && !load0) begin
      fall0 = cyc0;
      falls0.push_back(cyc0);
      nb0 = 0;
    end
    if (!ps0 && sclk0 && !load0) begin
      sh0 = {sh0[14:0], dout0};
      nb0++;
    end
    if (!pl0 && load0) begin
      if (nb0 == 16) begin
        frames0.push_back(sh0);
        lowlen0.push_back(cyc0 - fall0);
        if (sh0[11:8] >= 4'd1 && sh0[11:8] <= 4'd8) digit_reg[sh0[10:8] - 3'd1] = sh0[7:0];
      end else begin
        aborts0++;
      end
    end
    pl0 = load0;
    ps0 = sclk0;
    pd0 = dout0;
  end

  // Monitor for the CLK_DIV=1 instance
  logic [15:0] frames1[$];
  int          lowlen1[$];
  int          falls1[$];
  int cyc1 = 0, fall1 = 0, nb1 = 0, viol1 = 0;
  logic pl1 = 1'b1, ps1 = 1'b0, pd1 = 1'b0;
  logic [15:0] sh1 = '0;

  always @(negedge clk) begin
    cyc1++;
    if (dout1 !== pd1 && sclk1 === 1'b1) viol1++;
    if (sclk1 === 1'b1 && load1 === 1'b1) viol1++;
    if (pl1 && !load1) begin
      fall1 = cyc1;
      falls1.push_back(cyc1);
      nb1 = 0;
    end
    if (!ps1 && sclk1 && !load1) begin
      sh1 = {sh1[14:0], dout1};
      nb1++;
    end
    if (!pl1 && load1 && nb1 == 16) begin
      frames1.push_back(sh1);
      lowlen1.push_back(cyc1 - fall1);
    end
    pl1 = load1;
    ps1 = sclk1;
    pd1 = dout1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input int which, input int limit, input string tag);
    int n = 0;
    while (((which == 0) ? busy0 : busy1) !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, ((which == 0) ? busy0 : busy1), 1'b0);
  endtask

  task automatic wait_frames(input int count, input int limit, input string tag);
    int n = 0;
    while (frames0.size() < count && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, frames0.size(), count);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic clear_mon();
    frames0.delete(); lowlen0.delete(); falls0.delete();
    frames1.delete(); lowlen1.delete(); falls1.delete();
  endtask

  logic [15:0] init_exp[5] = '{16'h0F00, 16'h0C01, 16'h0900, 16'h0B07, 16'h0A08};
  logic [15:0] init_exp1[5] = '{16'h0F00, 16'h0C01, 16'h0900, 16'h0B07, 16'h0A0F};
  logic [15:0] dig_exp[8] = '{16'h015F, 16'h025B, 16'h0370, 16'h0433,
                              16'h0579, 16'h066D, 16'h0730, 16'h087E};
  logic [63:0] digits_b = 64'h7E30_6D79_3370_5B5F;
  logic [63:0] digits_a = 64'h0102_0304_0506_0708;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_sclk", sclk0, 1'b0);
    check_eq("rst_dout", dout0, 1'b0);
    check_eq("rst_load", load0, 1'b1);
    check_eq("rst_busy", busy0, 1'b1);
    check_eq("rst_load1", load1, 1'b1);
    clear_mon();
    reset = 1'b0;
    @(negedge clk);
    check_eq("first_fall", load0, 1'b0);

    // Init sequence, both instances
    wait_idle(1, 400, "init1_idle");
    wait_idle(0, 800, "init_idle");
    check_eq("init_count", frames0.size(), 5);
    for (int i = 0; i < 5 && i < frames0.size(); i++) begin
      check_eq($sformatf("init_frame%0d", i), frames0[i], init_exp[i]);
      check_eq($sformatf("init_low%0d", i), lowlen0[i], 66);
    end
    for (int i = 0; i < 4 && i + 1 < falls0.size(); i++)
      check_eq($sformatf("init_period%0d", i), falls0[i+1] - falls0[i], 68);
    check_eq("init1_count", frames1.size(), 5);
    for (int i = 0; i < 5 && i < frames1.size(); i++) begin
      check_eq($sformatf("init1_frame%0d", i), frames1[i], init_exp1[i]);
      check_eq($sformatf("init1_low%0d", i), lowlen1[i], 33);
    end
    for (int i = 0; i < 4 && i + 1 < falls1.size(); i++)
      check_eq($sformatf("init1_period%0d", i), falls1[i+1] - falls1[i], 34);

    // Single refresh
    clear_mon();
    digits = digits_b;
    pulse_update();
    check_eq("upd_busy", busy0, 1'b1);
    wait_idle(0, 1000, "dig_idle");
    check_eq("dig_count", frames0.size(), 8);
    for (int i = 0; i < 8 && i < frames0.size(); i++)
      check_eq($sformatf("dig_frame%0d", i), frames0[i], dig_exp[i]);
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("dig_reg%0d", k), digit_reg[k], digits_b[8*k +: 8]);

    // Merged pending strobes; snapshot must hold during the running sequence
    clear_mon();
    digits = digits_a;
    pulse_update();
    wait_frames(2, 400, "pend_wait2");
    pulse_update();
    @(negedge clk);
    pulse_update();
    @(negedge clk);
    pulse_update();
    digits = {8{8'hFF}};
    check_eq("pend_in_seq", frames0.size() < 8, 1'b1);
    wait_idle(0, 2000, "pend_idle");
    check_eq("pend_count", frames0.size(), 16);
    for (int i = 0; i < 16 && i < frames0.size(); i++)
      check_eq($sformatf("pend_frame%0d", i), frames0[i],
               (i < 8) ? {4'h0, 4'(i + 1), 8'(8 - i)} : {4'h0, 4'(i - 7), 8'hFF});
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("pend_reg%0d", k), digit_reg[k], 8'hFF);

    // Reset in the middle of the 3rd digit frame
    clear_mon();
    digits = digits_a;
    pulse_update();
    wait_frames(2, 400, "abort_wait2");
    begin
      int n = 0;
      while (load0 !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (sclk0 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check_eq("abort_midbit", sclk0, 1'b1);
    end
    begin
      int ab = aborts0;
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_load", load0, 1'b1);
      check_eq("abort_sclk", sclk0, 1'b0);
      check_eq("abort_busy", busy0, 1'b1);
      @(negedge clk);
      check_eq("abort_nolatch", frames0.size(), 2);
      check_eq("abort_partial", aborts0 - ab, 1);
    end
    reset = 1'b0;
    wait_idle(0, 800, "reinit_idle");
    check_eq("reinit_count", frames0.size(), 7);
    for (int i = 0; i < 5 && i + 2 < frames0.size(); i++)
      check_eq($sformatf("reinit_frame%0d", i), frames0[i+2], init_exp[i]);

    // Protocol rules over the whole run
    check_eq("proto0", viol0, 0);
    check_eq("proto1", viol1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
